demux1t2_32_stream: RTL and testbench

//   Registered 1-to-2 stream demultiplexer, the distributing counterpart of the 2:1 32-bit mux.

---
 rtl/demux1t2_32_stream.sv | 106 ++++++++++
 tb/tb_demux1t2_32_stream.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/demux1t2_32_stream.sv
// Registered 1-to-2 valid/ready stream demultiplexer with per-channel
// one-entry output register and transfer counter.
module demux1t2_32_stream #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             i_ready,
  output logic             o0_valid,
  output logic [WIDTH-1:0] o0_data,
  input  logic             o0_ready,
  output logic             o1_valid,
  output logic [WIDTH-1:0] o1_data,
  input  logic             o1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic             busy
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  logic [1:0]       w_out_ready;
  logic [1:0]       w_room;
  logic [1:0]       w_valid_nxt;
  logic [1:0]       w_valid;
  logic [WIDTH-1:0] w_data [2];
  logic [CNT_W-1:0] w_cnt  [2];
  logic             r_busy;

  assign w_out_ready = {o1_ready, o0_ready};

  // Only the selected channel can stall the producer.
  assign i_ready = s ? w_room[1] : w_room[0];

  for (genvar k = 0; k < 2; k++) begin : g_ch
    localparam logic SEL = (k == 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;
    logic             w_push;
    logic             w_pop;

    assign w_pop     = (r_state == ST_FULL) & w_out_ready[k];
    assign w_push    = i_valid & i_ready & (s == SEL);
    assign w_room[k] = (r_state == ST_EMPTY) | w_out_ready[k];
    assign w_valid_nxt[k] = w_push | ((r_state == ST_FULL) & ~w_pop);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= ST_EMPTY;
        r_data  <= '0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_EMPTY: begin
            if (w_push) begin
              r_state <= ST_FULL;
              r_data  <= i_data;
            end
          end
          ST_FULL: begin
            // A push in the same cycle as a pop refills the register directly.
            if (w_push) begin
              r_data <= i_data;
            end else if (w_pop) begin
              r_state <= ST_EMPTY;
            end
          end
          default: r_state <= ST_EMPTY;
        endcase
        if (w_pop) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end

    assign w_valid[k] = (r_state == ST_FULL);
    assign w_data[k]  = r_data;
    assign w_cnt[k]   = r_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= |w_valid_nxt;
    end
  end

  assign o0_valid = w_valid[0];
  assign o1_valid = w_valid[1];
  assign o0_data  = w_data[0];
  assign o1_data  = w_data[1];
  assign cnt0     = w_cnt[0];
  assign cnt1     = w_cnt[1];
  assign busy     = r_busy;

endmodule

// File: tb/tb_demux1t2_32_stream.sv
// Scoreboard bench for demux1t2_32_stream: stimulus pushes expected words,
// a monitor pops and compares on every output transfer.
module tb_demux1t2_32_stream;

  localparam int unsigned W   = 32;
  localparam int unsigned CW  = 4;
  localparam int          MOD = 1 << CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          s;
  logic          i_valid;
  logic [W-1:0]  i_data;
  logic          i_ready;
  logic          o0_valid, o1_valid;
  logic [W-1:0]  o0_data, o1_data;
  logic          o0_ready, o1_ready;
  logic [CW-1:0] cnt0, cnt1;
  logic          busy;

  demux1t2_32_stream #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .s(s), .i_valid(i_valid), .i_data(i_data),
    .i_ready(i_ready),
    .o0_valid(o0_valid), .o0_data(o0_data), .o0_ready(o0_ready),
    .o1_valid(o1_valid), .o1_data(o1_data), .o1_ready(o1_ready),
    .cnt0(cnt0), .cnt1(cnt1), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: words accepted but not yet transferred, per channel.
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W-1:0] last0 = '0;
  logic [W-1:0] last1 = '0;
  int           mcnt0 = 0;
  int           mcnt1 = 0;
  bit           mon_en = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples 2 time units after the falling edge.
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      chk("o0_valid", W'(o0_valid), W'(q0.size() != 0));
      chk("o1_valid", W'(o1_valid), W'(q1.size() != 0));
      chk("o0_data", o0_data, (q0.size() != 0) ? q0[0] : last0);
      chk("o1_data", o1_data, (q1.size() != 0) ? q1[0] : last1);
      chk("cnt0", W'(cnt0), W'(mcnt0));
      chk("cnt1", W'(cnt1), W'(mcnt1));
      chk("busy", W'(busy), W'((q0.size() != 0) || (q1.size() != 0)));
      if (q0.size() != 0 && o0_ready) begin
        last0 = q0.pop_front();
        mcnt0 = (mcnt0 + 1) % MOD;
      end
      if (q1.size() != 0 && o1_ready) begin
        last1 = q1.pop_front();
        mcnt1 = (mcnt1 + 1) % MOD;
      end
    end
  end

  // One clock cycle of stimulus; the accepted word is queued after the edge.
  task automatic cycle(input logic v, input logic sel, input logic [W-1:0] d,
                       input logic r0, input logic r1);
    logic exp_rdy;
    logic acc;
    @(negedge clk);
    i_valid  = v;
    s        = sel;
    i_data   = d;
    o0_ready = r0;
    o1_ready = r1;
    #1;
    exp_rdy = sel ? ((q1.size() == 0) || r1) : ((q0.size() == 0) || r0);
    chk("i_ready", W'(i_ready), W'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk);
    #1;
    if (acc) begin
      if (sel) q1.push_back(d);
      else     q0.push_back(d);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_o0_valid"}, W'(o0_valid), '0);
    chk({tag, "_o1_valid"}, W'(o1_valid), '0);
    chk({tag, "_o0_data"}, o0_data, '0);
    chk({tag, "_o1_data"}, o1_data, '0);
    chk({tag, "_cnt0"}, W'(cnt0), '0);
    chk({tag, "_cnt1"}, W'(cnt1), '0);
    chk({tag, "_busy"}, W'(busy), '0);
  endtask

  initial begin
    rst = 1'b1; s = 1'b0; i_valid = 1'b0; i_data = '0;
    o0_ready = 1'b0; o1_ready = 1'b0;
    #3;
    check_reset_state("por");
    #3;
    rst = 1'b0;
    mon_en = 1'b1;

    // Routing to both channels
    cycle(1'b1, 1'b0, 32'hA5A5_0001, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 32'h5A5A_0002, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, '0, 1'b1, 1'b1);

    // Backpressure on channel 0
    cycle(1'b1, 1'b0, 32'h1, 1'b0, 1'b1);
    for (int unsigned i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h2, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 32'h2, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Independence: ch0 stalled full, ch1 still accepts
    cycle(1'b1, 1'b0, 32'h0BAD_0BAD, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h1111_2222, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Streaming 100 words to ch1, counter wraps several times
    for (int unsigned i = 0; i < 100; i++)
      cycle(1'b1, 1'b1, $urandom, 1'($urandom_range(0, 1)), 1'b1);
    cycle(1'b0, 1'b1, '0, 1'b1, 1'b1);

    // Wrap on ch0: 17 back-to-back transfers
    for (int unsigned i = 0; i < 17; i++)
      cycle(1'b1, 1'b0, $urandom, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic
    for (int unsigned i = 0; i < 3000; i++)
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));

    // Asynchronous reset while ch0 holds a word
    cycle(1'b1, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0);
    #1;
    chk("pre_rst_o0_valid", W'(o0_valid), W'(q0.size() != 0));
    #1;
    rst = 1'b1;
    #1;
    check_reset_state("async");
    q0.delete(); q1.delete();
    last0 = '0; last1 = '0; mcnt0 = 0; mcnt1 = 0;
    i_valid = 1'b0;
    rst = 1'b0;

    for (int unsigned i = 0; i < 200; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int unsigned i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);

    @(negedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
